// File: rtl/hamming74_pkg.sv
// hamming74_pkg: shared Hamming(7,4) constants, encode/syndrome helpers and the transmitter FSM state type.
//   N/K       : codeword and data widths
//   NO_INJ    : injection position meaning "no flip"
//   state_t   : S_IDLE, S_SHIFT, S_GAP
package hamming74_pkg;

    localparam int         N      = 7;
    localparam int         K      = 4;
    localparam logic [2:0] NO_INJ = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    // c[6:3] = d[3:0]; parity bits chosen so every receiver syndrome is 0 on a clean word.
    function automatic logic [N-1:0] ham74_encode(input logic [K-1:0] d);
        return {d, d[1] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[2], d[0] ^ d[2] ^ d[3]};
    endfunction

    // s[0] = c0^c3^c5^c6, s[1] = c1^c3^c4^c5, s[2] = c2^c4^c5^c6
    function automatic logic [2:0] ham74_syndrome(input logic [N-1:0] r);
        return {r[2] ^ r[4] ^ r[5] ^ r[6], r[1] ^ r[3] ^ r[4] ^ r[5], r[0] ^ r[3] ^ r[5] ^ r[6]};
    endfunction

endpackage

// File: rtl/hamming74_enc.sv
// hamming74_enc: combinational Hamming(7,4) encoder.
//   i_d [3:0] : data word
//   o_c [6:0] : codeword, c[6:3] = data, c[2:0] = parity
module hamming74_enc
    import hamming74_pkg::*;
(
    input  logic [K-1:0] i_d,
    output logic [N-1:0] o_c
);

    assign o_c = ham74_encode(i_d);

endmodule

// File: rtl/hamming74_serial_tx.sv
// hamming74_serial_tx: accepts 4-bit words on valid/ready, Hamming(7,4)-encodes them with optional single-bit
// error injection, and shifts each codeword out MSB first, one bit per clock.
//   clk, reset         : clock, synchronous active-high reset
//   i_in_valid/o_in_ready, i_in_data : input handshake and data word
//   i_inj_en, i_inj_pos: flip codeword bit i_inj_pos (7 = no flip), sampled with the data
//   o_tx, o_tx_valid, o_tx_sof : registered serial bit, bit-valid, first-bit marker
//   o_busy             : FSM not idle
//   o_cw_dbg           : codeword being sent (after injection), holds when idle
module hamming74_serial_tx
    import hamming74_pkg::*;
#(
    parameter int GAP   = 0,
    parameter int GAP_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_in_valid,
    input  logic [K-1:0] i_in_data,
    input  logic         i_inj_en,
    input  logic [2:0]   i_inj_pos,
    output logic         o_in_ready,
    output logic         o_tx,
    output logic         o_tx_valid,
    output logic         o_tx_sof,
    output logic         o_busy,
    output logic [N-1:0] o_cw_dbg
);

    // The IDLE cycle in which the next word is accepted is itself the last idle bit-time, so the GAP
    // state only needs to cover GAP-1 cycles for the line to stay quiet for exactly GAP cycles.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP > 1 ? GAP - 2 : 0);

    state_t           r_state;
    logic [2:0]       r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [N-1:0]     r_sr;
    logic             r_tx;
    logic             r_tx_valid;
    logic             r_tx_sof;
    logic [N-1:0]     r_cw_dbg;

    logic [N-1:0]     w_c;
    logic [N-1:0]     w_cw;
    logic             w_last;
    logic             w_xfer;

    hamming74_enc u_enc (
        .i_d (i_in_data),
        .o_c (w_c)
    );

    assign w_cw       = w_c ^ ((i_inj_en && i_inj_pos != NO_INJ) ? N'(1) << i_inj_pos : '0);
    assign w_last     = r_state == S_SHIFT && r_bit_cnt == 3'd6;
    assign o_in_ready = r_state == S_IDLE || (w_last && GAP == 0);
    assign w_xfer     = i_in_valid && o_in_ready;

    assign o_tx       = r_tx;
    assign o_tx_valid = r_tx_valid;
    assign o_tx_sof   = r_tx_sof;
    assign o_busy     = r_state != S_IDLE;
    assign o_cw_dbg   = r_cw_dbg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_sr       <= '0;
            r_tx       <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_sof   <= 1'b0;
            r_cw_dbg   <= '0;
        end else if (w_xfer) begin
            // c[6] goes straight to the output register; the shifter keeps the remaining six bits.
            r_state    <= S_SHIFT;
            r_bit_cnt  <= '0;
            r_sr       <= {w_cw[N-2:0], 1'b0};
            r_tx       <= w_cw[N-1];
            r_tx_valid <= 1'b1;
            r_tx_sof   <= 1'b1;
            r_cw_dbg   <= w_cw;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_tx_sof <= 1'b0;
                    if (w_last) begin
                        r_state    <= GAP > 1 ? S_GAP : S_IDLE;
                        r_bit_cnt  <= '0;
                        r_gap_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_tx_valid <= 1'b0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_sr      <= r_sr << 1;
                        r_tx      <= r_sr[N-1];
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                    if (r_gap_cnt == GAP_LAST) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
